// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a writable note program as a square wave with
// play/pause/stop control, optional looping and an end-of-song done pulse.
module tone_sequencer #(
    parameter int MAX_LEN    = 64,
    parameter int DUR_W      = 2,
    parameter int TICK_DIV   = 30000000,
    parameter int TONE_SHIFT = 0
) (
    input  logic               clk100mhz,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [7:0]         how_long,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [5+DUR_W-1:0] wr_data,
    output logic               sound,
    output logic               playing,
    output logic               paused,
    output logic [7:0]         play_position,
    output logic [4:0]         play_note,
    output logic               done
);
    // state | meaning
    // IDLE  | stopped, outputs at rest values, program writable
    // PLAY  | sounding note play_position, tick/duration/tone counters running
    // PAUSE | counters frozen, sound held low

    localparam int NOTE_W = 5 + DUR_W;
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        LEN_MAX   = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          pos_q, pos_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W:0]      dur_q, dur_d;
    logic [31:0]         tone_q, tone_d;
    logic                sound_q, sound_d;
    logic                done_q, done_d;

    logic [NOTE_W-1:0]   mem_q [MAX_LEN];

    logic [7:0]          len;
    logic [31:0]         base_p;
    logic [31:0]         half_sh;
    logic [31:0]         half;
    logic                is_rest;
    logic                tick_wrap;
    logic                note_end;
    logic [8:0]          pos_inc;
    logic                has_next;
    logic [7:0]          load_pos;

    // Unshifted half-period in clocks; zero marks a rest (degree 0 or octave 3).
    function automatic logic [31:0] base_half(input logic [4:0] code);
        case (code)
            5'b00_001: base_half = 32'd191110;
            5'b00_010: base_half = 32'd170265;
            5'b00_011: base_half = 32'd151685;
            5'b00_100: base_half = 32'd143172;
            5'b00_101: base_half = 32'd127551;
            5'b00_110: base_half = 32'd113636;
            5'b00_111: base_half = 32'd101239;
            5'b01_001: base_half = 32'd95557;
            5'b01_010: base_half = 32'd85131;
            5'b01_011: base_half = 32'd75844;
            5'b01_100: base_half = 32'd71586;
            5'b01_101: base_half = 32'd63776;
            5'b01_110: base_half = 32'd56818;
            5'b01_111: base_half = 32'd50619;
            5'b10_001: base_half = 32'd47778;
            5'b10_010: base_half = 32'd42566;
            5'b10_011: base_half = 32'd37922;
            5'b10_100: base_half = 32'd35793;
            5'b10_101: base_half = 32'd31888;
            5'b10_110: base_half = 32'd28409;
            5'b10_111: base_half = 32'd25310;
            default:   base_half = 32'd0;
        endcase
    endfunction

    always_comb begin
        len       = (how_long > LEN_MAX) ? LEN_MAX : how_long;
        base_p    = base_half(note_q[4:0]);
        is_rest   = (base_p == 32'd0);
        half_sh   = base_p >> TONE_SHIFT;
        half      = (half_sh == 32'd0) ? 32'd1 : half_sh;
        tick_wrap = (tick_q == TICK_LAST);
        note_end  = tick_wrap && (dur_q == {1'b0, note_q[NOTE_W-1:5]});
        pos_inc   = {1'b0, pos_q} + 9'd1;
        has_next  = (pos_inc < {1'b0, len});
        load_pos  = has_next ? pos_inc[7:0] : 8'd0;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        note_d  = note_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        sound_d = sound_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (len != 8'd0)) begin
                    state_d = S_PLAY;
                    pos_d   = '0;
                    note_d  = mem_q[0];
                    tick_d  = '0;
                    dur_d   = '0;
                    tone_d  = '0;
                    sound_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (is_rest) begin
                    tone_d  = '0;
                    sound_d = 1'b0;
                end else if (tone_q >= half - 32'd1) begin
                    tone_d  = '0;
                    sound_d = ~sound_q;
                end else begin
                    tone_d = tone_q + 32'd1;
                end

                tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                if (tick_wrap) begin
                    dur_d = dur_q + (DUR_W+1)'(1);
                end

                if (note_end) begin
                    if (has_next || loop_en) begin
                        pos_d   = load_pos;
                        note_d  = mem_q[load_pos[ADDR_W-1:0]];
                        dur_d   = '0;
                        tone_d  = '0;
                        sound_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end

                // The pausing edge still counts; end-of-song takes priority.
                if (start && (state_d == S_PLAY)) begin
                    state_d = S_PAUSE;
                    sound_d = 1'b0;
                end
            end
            S_PAUSE: begin
                sound_d = 1'b0;
                if (start) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        if (state_d == S_IDLE) begin
            pos_d   = '0;
            note_d  = '0;
            tick_d  = '0;
            dur_d   = '0;
            tone_d  = '0;
            sound_d = 1'b0;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (clr) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            note_q  <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            tone_q  <= '0;
            sound_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            note_q  <= note_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            sound_q <= sound_d;
            done_q  <= done_d;
        end
    end

    // Program memory survives clr; writes only land while stopped.
    always_ff @(posedge clk100mhz) begin
        if (wr_en && (state_q == S_IDLE) && (32'(wr_addr) < MAX_LEN)) begin
            mem_q[wr_addr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign sound         = sound_q;
    assign playing       = (state_q == S_PLAY);
    assign paused        = (state_q == S_PAUSE);
    assign play_position = pos_q;
    assign play_note     = note_q[4:0];
    assign done          = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: pitch/duration table plus
// hand-written loop, pause, stop, write-protect, reset and clamp sequences.
module tb_tone_sequencer;
    localparam int ML = 64;
    localparam int DW = 2;
    localparam int TD = 250;
    localparam int TS = 10;

    logic       clk100mhz = 1'b0;
    logic       clr, start, stop, loop_en, wr_en;
    logic [7:0] how_long, wr_addr;
    logic [6:0] wr_data;
    logic       sound, playing, paused, done;
    logic [7:0] play_position;
    logic [4:0] play_note;

    int checks = 0;
    int errors = 0;

    tone_sequencer #(
        .MAX_LEN(ML), .DUR_W(DW), .TICK_DIV(TD), .TONE_SHIFT(TS)
    ) dut (
        .clk100mhz(clk100mhz), .clr(clr), .start(start), .stop(stop),
        .loop_en(loop_en), .how_long(how_long), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .sound(sound),
        .playing(playing), .paused(paused), .play_position(play_position),
        .play_note(play_note), .done(done)
    );

    always #5 clk100mhz = ~clk100mhz;

    typedef struct {
        string name;
        int    code;
        int    dur;
        int    half;
        int    len;
    } vec_t;

    typedef struct {
        int code;
        int half;
        int len;
    } exp_t;

    typedef struct {
        int pos;
        int at;
        int code;
    } ev_t;

    vec_t vecs[8];
    exp_t sb[$];
    ev_t  evq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk100mhz);
    endtask

    task automatic wr(input int addr, input int dur, input int code);
        wr_en   = 1'b1;
        wr_addr = 8'(addr);
        wr_data = {2'(dur), 5'(code)};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic chk_rest(input string tag);
        chk({tag, "_playing"}, playing, 0);
        chk({tag, "_paused"}, paused, 0);
        chk({tag, "_sound"}, sound, 0);
        chk({tag, "_pos"}, play_position, 0);
        chk({tag, "_note"}, play_note, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Watches position changes for limit cycles after a start and matches them to evq.
    task automatic run_monitor(input int limit, output int done_seen);
        int   n;
        int   last;
        ev_t  e;
        n         = 0;
        last      = play_position;
        done_seen = 0;
        while (n < limit) begin
            step();
            n++;
            if (done) done_seen++;
            if (play_position != 8'(last)) begin
                last = play_position;
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_advance: got pos %0d at %0d expected none", play_position, n);
                end else begin
                    e = evq.pop_front();
                    chk("adv_pos", play_position, e.pos);
                    chk("adv_time", n, e.at);
                    chk("adv_note", play_note, e.code);
                end
            end
        end
        chk("events_left", evq.size(), 0);
    endtask

    initial begin
        int   n, rise, fall, done_at, hi, done_seen;
        exp_t e;

        vecs[0] = '{"oct1_deg1", 9,  1, 93,  2*TD};
        vecs[1] = '{"rest_deg0", 0,  0, 0,   1*TD};
        vecs[2] = '{"oct0_deg1", 1,  1, 186, 2*TD};
        vecs[3] = '{"oct2_deg7", 23, 0, 24,  1*TD};
        vecs[4] = '{"rest_oct3", 27, 0, 0,   1*TD};
        vecs[5] = '{"oct1_deg5", 13, 3, 62,  4*TD};
        vecs[6] = '{"oct2_deg1", 17, 2, 46,  3*TD};
        vecs[7] = '{"oct0_deg7", 7,  0, 98,  1*TD};

        clr = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
        how_long = 8'd1; wr_addr = 8'd0; wr_data = 7'd0;
        repeat (3) step();
        clr = 1'b0;
        chk_rest("reset");

        // Pitch and duration table, single non-looping note each.
        for (int i = 0; i < 8; i++) begin
            wr(0, vecs[i].dur, vecs[i].code);
            how_long = 8'd1;
            loop_en  = 1'b0;
            sb.push_back('{vecs[i].code, vecs[i].half, vecs[i].len});
            pulse_start();
            e = sb.pop_front();
            chk({vecs[i].name, "_load_note"}, play_note, e.code);
            chk({vecs[i].name, "_load_playing"}, playing, 1);
            chk({vecs[i].name, "_load_sound"}, sound, 0);
            n = 0; rise = 0; fall = 0; done_at = 0;
            while (done_at == 0 && n < e.len + 100) begin
                step();
                n++;
                if (sound && rise == 0) rise = n;
                if (!sound && rise != 0 && fall == 0) fall = n;
                if (done) begin
                    done_at = n;
                    chk({vecs[i].name, "_end_playing"}, playing, 0);
                    chk({vecs[i].name, "_end_sound"}, sound, 0);
                end
            end
            chk({vecs[i].name, "_first_rise"}, rise, e.half);
            if (e.half != 0) chk({vecs[i].name, "_half_period"}, fall - rise, e.half);
            chk({vecs[i].name, "_note_len"}, done_at, e.len);
            step();
            chk({vecs[i].name, "_done_width"}, done, 0);
        end

        // Three-note looping program.
        wr(0, 0, 9);
        wr(1, 1, 13);
        wr(2, 0, 23);
        how_long = 8'd3;
        loop_en  = 1'b1;
        evq.push_back('{1, 1*TD, 13});
        evq.push_back('{2, 3*TD, 23});
        evq.push_back('{0, 4*TD, 9});
        evq.push_back('{1, 5*TD, 13});
        evq.push_back('{2, 7*TD, 23});
        pulse_start();
        chk("loop_start_pos", play_position, 0);
        run_monitor(7*TD + 150, done_seen);
        chk("loop_done_count", done_seen, 0);
        pulse_stop();
        chk_rest("loop_stop");

        // Pause 400 clocks into a 1000-clock note, hold 5000, resume.
        wr(0, 3, 9);
        how_long = 8'd1;
        loop_en  = 1'b0;
        pulse_start();
        repeat (399) step();
        pulse_start();
        chk("pause_entered", paused, 1);
        chk("pause_sound0", sound, 0);
        hi = 0;
        for (int k = 0; k < 4999; k++) begin
            step();
            if (sound) hi++;
        end
        chk("pause_sound_hi_cycles", hi, 0);
        chk("pause_held", paused, 1);
        pulse_start();
        chk("resume_playing", playing, 1);
        n = 0; done_at = 0;
        while (done_at == 0 && n < 800) begin
            step();
            n++;
            if (done) done_at = n;
        end
        chk("resume_remaining", done_at, 600);

        // Simultaneous stop and start while playing.
        wr(0, 3, 9);
        pulse_start();
        repeat (100) step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk_rest("stop_wins");

        // Writes while playing are ignored.
        pulse_start();
        wr(0, 3, 23);
        pulse_stop();
        pulse_start();
        chk("play_write_ignored", play_note, 9);
        pulse_stop();

        // Out-of-range address is dropped, not aliased.
        wr(ML, 3, 17);
        pulse_start();
        chk("oob_write_dropped", play_note, 9);
        pulse_stop();

        // Write and start together: note 0 comes from the pre-write contents.
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = {2'd3, 5'd23}; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("wr_start_old_note", play_note, 9);
        pulse_stop();
        pulse_start();
        chk("wr_start_new_note", play_note, 23);

        // clr mid-note.
        repeat (200) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_rest("clr_mid");
        pulse_start();
        chk("mem_kept_after_clr", play_note, 23);
        pulse_stop();

        // Zero length is ignored.
        how_long = 8'd0;
        pulse_start();
        repeat (5) step();
        chk("len0_idle", playing, 0);
        chk("len0_pos", play_position, 0);

        // Length above MAX_LEN clamps and wraps after position ML-1.
        for (int i = 0; i < ML; i++) wr(i, 0, i % 32);
        how_long = 8'd200;
        loop_en  = 1'b1;
        for (int k = 1; k <= ML; k++) evq.push_back('{k % ML, k*TD, (k % ML) % 32});
        pulse_start();
        run_monitor(ML*TD + 50, done_seen);
        chk("clamp_done_count", done_seen, 0);
        pulse_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the single-song player.
- Holds a writable note program of up to MAX_LEN entries. Each entry is a 5-bit pitch code plus a per-note duration.
- Plays the program as a square wave with play/pause/stop control, optional looping and a one-cycle done pulse.
- Sits between the key/switch front end and the speaker pin. Drives the LED position and note displays.

Parameters:
- MAX_LEN, 64, program depth in notes; 1..255.
- DUR_W, 2, duration field width. A note lasts (dur+1) ticks.
- TICK_DIV, 30000000, clk100mhz cycles per duration tick; >=1.
- TONE_SHIFT, 0, right shift applied to every half-period constant (simulation speed-up). A result below 1 is forced to 1.

Ports:
- clk100mhz  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; play/pause toggle.
- stop  in  1  one-cycle pulse; abort to idle.
- loop_en  in  1  1 = wrap to note 0 after the last note.
- how_long  in  8  song length in notes. Values above MAX_LEN are clamped to MAX_LEN.
- wr_en  in  1  program write strobe. Honoured only in IDLE.
- wr_addr  in  8  program address. Writes with wr_addr >= MAX_LEN are dropped.
- wr_data  in  5+DUR_W  {dur, octave[1:0], degree[2:0]}.
- sound  out  1  square-wave speaker drive.
- playing  out  1  1 in PLAY state.
- paused  out  1  1 in PAUSE state.
- play_position  out  8  index of the note currently sounding.
- play_note  out  5  {octave, degree} of the current note.
- done  out  1  one-cycle pulse at end of a non-looping song.

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE; sound=0, playing=0, paused=0, done=0, play_position=0, play_note=0.
  - Tick, duration and tone counters cleared.
  - Program memory is NOT cleared.
- Pitch table, half-period in clocks before shift:
  - octave 0 (low), degrees 1..7: 191110, 170265, 151685, 143172, 127551, 113636, 101239.
  - octave 1 (mid), degrees 1..7: 95557, 85131, 75844, 71586, 63776, 56818, 50619.
  - octave 2 (high), degrees 1..7: 47778, 42566, 37922, 35793, 31888, 28409, 25310.
  - degree 0 or octave 3 = rest: sound is held 0 and does not toggle.
- States IDLE / PLAY / PAUSE:
  - IDLE + start, with clamped length L > 0 → PLAY. Note 0 is loaded on the same edge: play_position=0, play_note=mem[0], duration counter=0, tone counter=0, sound=0.
  - IDLE + start with L = 0 is ignored.
  - PLAY + start → PAUSE. PAUSE + start → PLAY.
  - Any state + stop → IDLE with the reset output values (memory kept).
  - Simultaneous stop and start: stop wins.
- Tone generation:
  - In PLAY a 32-bit counter runs 0..H-1, where H is the shifted half-period.
  - sound toggles on each wrap to 0.
  - Loading a new note restarts the counter at 0 with sound=0, so every note starts phase-coherent.
- Pause:
  - Tick, duration and tone counters freeze; sound is forced to 0.
  - On resume, counting continues from the frozen values, so the remaining duration is preserved.
- Duration:
  - The tick counter counts 0..TICK_DIV-1.
  - Each wrap increments the duration counter.
  - When the duration counter reaches dur+1, advance to the next note on that same edge.
- Advance:
  - If play_position < L-1: load position+1.
  - Else if loop_en=1: load position 0.
  - Else → IDLE and pulse done=1 for exactly one cycle; sound=0.
- loop_en and how_long are sampled only at the end-of-song decision. Changing them mid-song is legal.
- Writes:
  - wr_en in IDLE writes mem[wr_addr] on the edge.
  - wr_en in PLAY/PAUSE is ignored.
  - A write and start in the same IDLE cycle: the write is performed, and note 0 is loaded from the pre-write contents.
- Counter and field widths: tick counter ceil(log2(TICK_DIV)); duration counter DUR_W+1 bits; no overflow permitted.

Test Plan:
1. TONE_SHIFT=10, TICK_DIV=1000; program mem[0]={dur=1, oct1, deg1}, how_long=1, loop_en=0; pulse start → sound half-period 93 clocks (95557>>10). Note lasts 2000 clocks, then done=1 for 1 cycle, playing=0.
2. Same setup with mem[0]={dur=0, oct0, deg0} (rest) → sound stays 0 for 1000 clocks, then done pulses.
3. 3-note program, loop_en=1, how_long=3 → play_position sequence 0,1,2,0,1… every (dur+1)*1000 clocks; done never asserts.
4. Pause 400 clocks into a 1000-clock note, hold paused 5000 clocks, resume → note ends 600 clocks after resume; sound=0 throughout pause.
5. stop and start asserted on the same cycle in PLAY → IDLE, all outputs at reset values. wr_en during PLAY to addr 0 → mem[0] unchanged on next play.
6. clr mid-note → outputs zero next edge. how_long=0 plus start → stays IDLE. how_long=200 with MAX_LEN=64 → wraps after position 63.
